// File: rtl/mult_div_unit_if.sv
// ============================================================================
// Module      : mult_div_unit_if
// Description : Pipeline-control <-> multiply/divide unit interface.
//               master = pipeline side (launches ops, writes HI/LO)
//               slave  = mult_div_unit side (holds HI/LO, reports status)
// Signals     : start, op[1:0], a, b, mthi, mtlo, wdata   (master -> slave)
//               hi, lo, busy, done, div_by_zero           (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU,
//               MTHI/MTLO). One radix-2 iteration per clock: shift-add for
//               multiply, restoring shift-subtract for divide, operating on
//               magnitudes with a final sign-fix cycle.
// Ports       : Clk           clock, all state changes on posedge
//               resetControl  synchronous active-high reset
//               bus (slave)   start/op/a/b/mthi/mtlo/wdata in,
//                             hi/lo/busy/done/div_by_zero out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic          Clk,
  input  wire logic          resetControl,
  mult_div_unit_if.slave     bus
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;   // raw dividend, returned as HI on /0
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  // opnd: multiplicand |a| for multiply, divisor |b| for divide
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // upper: partial product high half / partial remainder
  // lower: multiplier being shifted out / dividend shifting into quotient
  logic [WIDTH-1:0]   upper_q, upper_d;
  logic [WIDTH-1:0]   lower_q, lower_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Operand magnitudes at launch; only signed ops (op[0]==0) see a sign.
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;

  assign w_a_neg = ~bus.op[0] & bus.a[WIDTH-1];
  assign w_b_neg = ~bus.op[0] & bus.b[WIDTH-1];
  assign w_a_abs = w_a_neg ? -bus.a : bus.a;
  assign w_b_abs = w_b_neg ? -bus.b : bus.b;

  // Multiply step: conditional add into the high half, then shift the
  // whole {upper, lower} pair right by one (carry lands in upper MSB).
  logic [WIDTH:0]     w_mul_sum;
  assign w_mul_sum = {1'b0, upper_q} + (lower_q[0] ? {1'b0, opnd_q} : '0);

  // Divide step: bring the next dividend bit into the remainder and try
  // to subtract the divisor. The remainder is always < divisor, so the
  // shifted value fits in WIDTH+1 bits.
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_sub;
  logic               w_div_ge;
  assign w_div_shift = {upper_q, lower_q[WIDTH-1]};
  assign w_div_sub   = w_div_shift - {1'b0, opnd_q};
  assign w_div_ge    = (w_div_shift >= {1'b0, opnd_q});

  // Sign-fix candidates
  logic [2*WIDTH-1:0] w_prod, w_prod_neg;
  logic [WIDTH-1:0]   w_quo_neg, w_rem_neg;
  assign w_prod     = {upper_q, lower_q};
  assign w_prod_neg = -w_prod;
  assign w_quo_neg  = -lower_q;
  assign w_rem_neg  = -upper_q;

  always_ff @(posedge Clk) begin
    if (resetControl) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_orig_q <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      upper_q  <= '0;
      lower_q  <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_orig_q <= a_orig_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      opnd_q   <= opnd_d;
      upper_q  <= upper_d;
      lower_q  <= lower_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_orig_d = a_orig_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    opnd_d   = opnd_q;
    upper_d  = upper_q;
    lower_d  = lower_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // start wins over a simultaneous mthi/mtlo
          op_d     = bus.op;
          a_orig_d = bus.a;
          neg_a_d  = w_a_neg;
          neg_b_d  = w_b_neg;
          upper_d  = '0;
          cnt_d    = '0;
          if (bus.op[1]) begin
            lower_d = w_a_abs;
            opnd_d  = w_b_abs;
          end else begin
            lower_d = w_b_abs;
            opnd_d  = w_a_abs;
          end
          state_d  = ST_CALC;
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end

      ST_CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[1]) begin
          if (w_div_ge) begin
            upper_d = w_div_sub[WIDTH-1:0];
            lower_d = {lower_q[WIDTH-2:0], 1'b1};
          end else begin
            upper_d = w_div_shift[WIDTH-1:0];
            lower_d = {lower_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          upper_d = w_mul_sum[WIDTH:1];
          lower_d = {w_mul_sum[0], lower_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          // neg flags are only ever set for signed ops
          if (neg_a_q ^ neg_b_q) {hi_d, lo_d} = w_prod_neg;
          else                   {hi_d, lo_d} = w_prod;
        end else if (opnd_q == '0) begin
          hi_d  = a_orig_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          // remainder follows the dividend's sign; the min-negative / -1
          // case wraps naturally to 0x80..0 through the magnitude path
          lo_d = (neg_a_q ^ neg_b_q) ? w_quo_neg : lower_q;
          hi_d = neg_a_q ? w_rem_neg : upper_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire
